// File: rtl/led_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// led_scan_ctrl_if
// Handshake bundle between the LED source-scan sequencer and the 74HC595
// shift-register driver.
//   hc595d_data      : pattern to shift; bit k = chain output k
//   hc595d_data_len  : number of chain bits to shift
//   hc595d_wr_en     : write request; a rising edge starts a transfer
//   hc595d_wr_finish : driver status; high = idle / transfer done
// Modports: master = sequencer side, slave = driver side.
// -----------------------------------------------------------------------------
interface led_scan_ctrl_if;
    logic [127:0] hc595d_data;
    logic [7:0]   hc595d_data_len;
    logic         hc595d_wr_en;
    logic         hc595d_wr_finish;

    modport master (
        output hc595d_data,
        output hc595d_data_len,
        output hc595d_wr_en,
        input  hc595d_wr_finish
    );

    modport slave (
        input  hc595d_data,
        input  hc595d_data_len,
        input  hc595d_wr_en,
        output hc595d_wr_finish
    );
endinterface

// File: rtl/led_scan_ctrl.sv
// -----------------------------------------------------------------------------
// led_scan_ctrl
// Source-scan sequencer for the NIRS front end. For every time slot it writes a
// one-hot LED pattern to the 595 driver, waits for the latch, settles, then
// opens a sample window of fixed length. An optional dark slot (all LEDs off)
// follows the last source, and an all-zero blank write is issued whenever a
// scan ends or is aborted.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   scan_en     : level; frames repeat while high (sampled in IDLE / frame end)
//   scan_stop   : single-cycle abort request
//   bus         : driver handshake (led_scan_ctrl_if.master)
//   src_idx     : current slot (NUM_SRC = dark slot)
//   sample_win  : detector data for src_idx is valid
//   frame_done  : one-cycle pulse after the last slot's dwell
//   busy        : sequencer not idle
//   wr_err      : sticky driver-timeout flag, cleared at the next scan start
// -----------------------------------------------------------------------------
module led_scan_ctrl #(
    parameter int unsigned NUM_SRC    = 32,
    parameter int unsigned CHAIN_BITS = 32,
    parameter int unsigned SETTLE_CYC = 1000,
    parameter int unsigned DWELL_CYC  = 50000,
    parameter bit          DARK_EN    = 1'b1,
    parameter int unsigned WR_TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   scan_en,
    input  logic                   scan_stop,
    led_scan_ctrl_if.master        bus,
    output logic [6:0]             src_idx,
    output logic                   sample_win,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   wr_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WR_REQ, S_WR_ACK, S_WR_DONE,
        S_SETTLE, S_DWELL, S_NEXT, S_BLANK
    } state_e;

    localparam logic [127:0] CHAIN_MASK  = {128{1'b1}} >> (128 - CHAIN_BITS);
    localparam logic [6:0]   LAST_IDX    = DARK_EN ? 7'(NUM_SRC) : 7'(NUM_SRC - 1);
    localparam logic [31:0]  SETTLE_LAST = 32'(SETTLE_CYC - 1);
    localparam logic [31:0]  DWELL_LAST  = 32'(DWELL_CYC - 1);
    localparam logic [31:0]  TMO_LAST    = 32'(WR_TIMEOUT - 1);

    state_e        state_q;
    logic [127:0]  data_q;
    logic [7:0]    len_q;
    logic          wr_en_q;
    logic [6:0]    src_idx_q;
    logic          sample_win_q;
    logic          frame_done_q;
    logic          wr_err_q;
    logic [31:0]   cnt_q;        // shared by transfer timeout, settle and dwell
    logic          stop_pend_q;  // abort seen while a handshake was in flight
    logic          blank_q;      // current transfer is the closing blank write

    logic [127:0]  slot_pat_d;

    // Source slots light exactly one LED; the dark slot lights none.
    always_comb begin
        slot_pat_d = '0;
        if (src_idx_q < 7'(NUM_SRC)) begin
            slot_pat_d = (128'(1) << src_idx_q) & CHAIN_MASK;
        end
    end

    // NOTE: every register below is assigned with <= so all state updates
    // take effect together at the clock edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            data_q       <= '0;
            len_q        <= '0;
            wr_en_q      <= 1'b0;
            src_idx_q    <= '0;
            sample_win_q <= 1'b0;
            frame_done_q <= 1'b0;
            wr_err_q     <= 1'b0;
            cnt_q        <= '0;
            stop_pend_q  <= 1'b0;
            blank_q      <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (scan_en && bus.hc595d_wr_finish) begin
                        src_idx_q   <= '0;
                        wr_err_q    <= 1'b0;
                        stop_pend_q <= 1'b0;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (scan_stop) begin
                        state_q <= S_BLANK;
                    end else begin
                        len_q   <= 8'(CHAIN_BITS);
                        data_q  <= slot_pat_d;
                        cnt_q   <= '0;
                        blank_q <= 1'b0;
                        wr_en_q <= 1'b1;
                        state_q <= S_WR_REQ;
                    end
                end
                S_BLANK: begin
                    len_q       <= 8'(CHAIN_BITS);
                    data_q      <= '0;
                    cnt_q       <= '0;
                    blank_q     <= 1'b1;
                    stop_pend_q <= 1'b0;
                    wr_en_q     <= 1'b1;
                    state_q     <= S_WR_REQ;
                end
                S_WR_REQ: begin
                    if (scan_stop && !blank_q) stop_pend_q <= 1'b1;
                    if (cnt_q >= TMO_LAST) begin
                        wr_err_q <= 1'b1;
                        wr_en_q  <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                        if (!bus.hc595d_wr_finish) begin
                            wr_en_q <= 1'b0;
                            state_q <= S_WR_ACK;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (scan_stop && !blank_q) stop_pend_q <= 1'b1;
                    if (bus.hc595d_wr_finish) begin
                        if (blank_q)                        state_q <= S_IDLE;
                        else if (stop_pend_q || scan_stop)  state_q <= S_BLANK;
                        else                                state_q <= S_WR_DONE;
                    end else if (cnt_q >= TMO_LAST) begin
                        wr_err_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_WR_DONE: begin
                    cnt_q   <= '0;
                    state_q <= scan_stop ? S_BLANK : S_SETTLE;
                end
                S_SETTLE: begin
                    if (scan_stop) begin
                        state_q <= S_BLANK;
                    end else if (cnt_q >= SETTLE_LAST) begin
                        cnt_q        <= '0;
                        sample_win_q <= 1'b1;
                        state_q      <= S_DWELL;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_DWELL: begin
                    if (scan_stop) begin
                        sample_win_q <= 1'b0;
                        state_q      <= S_BLANK;
                    end else if (cnt_q >= DWELL_LAST) begin
                        sample_win_q <= 1'b0;
                        state_q      <= S_NEXT;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_NEXT: begin
                    if (scan_stop) begin
                        state_q <= S_BLANK;
                    end else if (src_idx_q < LAST_IDX) begin
                        src_idx_q <= src_idx_q + 7'd1;
                        state_q   <= S_LOAD;
                    end else begin
                        frame_done_q <= 1'b1;
                        if (scan_en) begin
                            src_idx_q <= '0;
                            state_q   <= S_LOAD;
                        end else begin
                            state_q <= S_BLANK;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.hc595d_data     = data_q;
    assign bus.hc595d_data_len = len_q;
    assign bus.hc595d_wr_en    = wr_en_q;
    assign src_idx             = src_idx_q;
    // NOTE: the abort must close the window in the same cycle, so the
    // registered window is gated combinationally by scan_stop.
    assign sample_win          = sample_win_q & ~scan_stop;
    assign frame_done          = frame_done_q;
    assign busy                = (state_q != S_IDLE);
    assign wr_err              = wr_err_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_scan_ctrl
// Self-checking bench for led_scan_ctrl with a behavioural 595 driver model.
// Written patterns are compared against a scoreboard queue as the driver
// latches them; sample windows and frame_done pulses are gathered by a monitor.
// -----------------------------------------------------------------------------
module tb_led_scan_ctrl;
    localparam int NUM_SRC    = 4;
    localparam int CHAIN_BITS = 8;
    localparam int SETTLE_CYC = 3;
    localparam int DWELL_CYC  = 10;
    localparam int WR_TIMEOUT = 16;

    logic clk;
    logic rst_n;
    logic scan_en;
    logic scan_stop;
    logic [6:0] src_idx;
    logic sample_win;
    logic frame_done;
    logic busy;
    logic wr_err;

    led_scan_ctrl_if bus ();

    led_scan_ctrl #(
        .NUM_SRC    (NUM_SRC),
        .CHAIN_BITS (CHAIN_BITS),
        .SETTLE_CYC (SETTLE_CYC),
        .DWELL_CYC  (DWELL_CYC),
        .DARK_EN    (1'b1),
        .WR_TIMEOUT (WR_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_en    (scan_en),
        .scan_stop  (scan_stop),
        .bus        (bus),
        .src_idx    (src_idx),
        .sample_win (sample_win),
        .frame_done (frame_done),
        .busy       (busy),
        .wr_err     (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard of expected latched patterns ----------------
    logic [127:0] exp_q[$];
    int           n_latch = 0;

    task automatic latch_pattern(input logic [127:0] pat);
        logic [127:0] exp;
        n_latch++;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got 0x%0h with no write pending", pat);
        end else begin
            exp = exp_q.pop_front();
            check("latched_pattern", pat, exp);
        end
    endtask

    // ---------------- 595 driver model ----------------
    logic         drv_no_resp;
    logic         drv_hold_busy;
    logic         drv_wr_en_q;
    int           drv_cnt;
    logic [127:0] drv_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.hc595d_wr_finish <= 1'b1;
            drv_wr_en_q          <= 1'b0;
            drv_cnt              <= 0;
            drv_data             <= '0;
        end else begin
            drv_wr_en_q <= bus.hc595d_wr_en;
            if (drv_cnt != 0) begin
                drv_cnt <= drv_cnt - 1;
                if (drv_cnt == 1) begin
                    bus.hc595d_wr_finish <= 1'b1;
                    check("data_stable", bus.hc595d_data, drv_data);
                    latch_pattern(drv_data);
                end
            end else if (drv_hold_busy) begin
                bus.hc595d_wr_finish <= 1'b0;
            end else if (bus.hc595d_wr_en && !drv_wr_en_q && !drv_no_resp) begin
                bus.hc595d_wr_finish <= 1'b0;
                drv_data             <= bus.hc595d_data;
                drv_cnt              <= int'(bus.hc595d_data_len) + 2;
            end else begin
                bus.hc595d_wr_finish <= 1'b1;
            end
        end
    end

    // ---------------- window / frame monitor ----------------
    typedef struct { int idx; int len; int gap; } win_t;
    win_t win_q[$];
    int   cyc = 0;
    int   last_latch_cyc = 0;
    int   win_len = 0;
    int   win_start = 0;
    int   win_idx = 0;
    int   fd_cnt = 0;
    logic fin_prev = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (bus.hc595d_wr_finish && !fin_prev) last_latch_cyc = cyc;
        fin_prev = bus.hc595d_wr_finish;
        if (sample_win) begin
            if (win_len == 0) begin
                win_start = cyc;
                win_idx   = int'(src_idx);
            end
            win_len++;
        end else if (win_len > 0) begin
            win_q.push_back('{win_idx, win_len, win_start - last_latch_cyc});
            win_len = 0;
        end
        if (frame_done) fd_cnt++;
    end

    // ---------------- helpers ----------------
    int fd_base;
    int latch_base;

    task automatic begin_test();
        fd_base    = fd_cnt;
        latch_base = n_latch;
        win_q.delete();
    endtask

    task automatic push_slots(input int upto);
        for (int s = 0; s <= upto; s++)
            exp_q.push_back(s < NUM_SRC ? (128'(1) << s) : 128'(0));
    endtask

    // NOTE: inputs change 1 time unit after the rising edge so the DUT never
    // sees them racing the edge that samples them.
    task automatic start_scan();
        @(posedge clk); #1 scan_en = 1'b1;
        @(posedge clk); #1 scan_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int guard = 0;
        do begin @(negedge clk); guard++; end while (busy && guard < 5000);
        check({tag, "_idle"}, 128'(busy), 128'(0));
    endtask

    task automatic run_frames(input int n);
        int guard = 0;
        begin_test();
        for (int f = 0; f < n; f++) push_slots(NUM_SRC);
        exp_q.push_back(128'(0));
        @(posedge clk); #1 scan_en = 1'b1;
        @(posedge clk); #1 if (n == 1) scan_en = 1'b0;
        @(negedge clk);
        check("load_no_wr_en", 128'(bus.hc595d_wr_en), 128'(0));
        check("load_busy", 128'(busy), 128'(1));
        @(negedge clk);
        check("wr_en_latency", 128'(bus.hc595d_wr_en), 128'(1));
        check("first_data", bus.hc595d_data, 128'h1);
        check("data_len", 128'(bus.hc595d_data_len), 128'(CHAIN_BITS));
        while (fd_cnt - fd_base < n - 1 && guard < 20000) begin
            @(posedge clk);
            guard++;
        end
        #1 scan_en = 1'b0;
        wait_idle("frames");
    endtask

    task automatic verify_frames(input int fd_exp, input int wins_exp, input int writes_exp);
        check("frame_done_count", 128'(fd_cnt - fd_base), 128'(fd_exp));
        check("window_count", 128'(win_q.size()), 128'(wins_exp));
        foreach (win_q[k]) begin
            check("window_src_idx", 128'(win_q[k].idx), 128'(k % (NUM_SRC + 1)));
            check("window_len", 128'(win_q[k].len), 128'(DWELL_CYC));
            check("latch_to_window", 128'(win_q[k].gap), 128'(SETTLE_CYC + 2));
        end
        check("write_count", 128'(n_latch - latch_base), 128'(writes_exp));
        check("writes_outstanding", 128'(exp_q.size()), 128'(0));
        check("wr_err_clear", 128'(wr_err), 128'(0));
    endtask

    typedef struct { int frames; int exp_fd; int exp_wins; int exp_writes; } frame_vec_t;
    frame_vec_t vecs[3];

    initial begin
        int guard;
        int cnt;
        vecs[0] = '{1, 1, 5, 6};
        vecs[1] = '{2, 2, 10, 11};
        vecs[2] = '{3, 3, 15, 16};

        scan_en       = 1'b0;
        scan_stop     = 1'b0;
        drv_no_resp   = 1'b0;
        drv_hold_busy = 1'b0;
        rst_n         = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_data", bus.hc595d_data, 128'(0));
        check("reset_len", 128'(bus.hc595d_data_len), 128'(0));
        check("reset_misc", 128'({bus.hc595d_wr_en, src_idx, sample_win, frame_done, busy, wr_err}), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Whole frames: single, continuous x2, continuous x3.
        foreach (vecs[i]) begin
            run_frames(vecs[i].frames);
            verify_frames(vecs[i].exp_fd, vecs[i].exp_wins, vecs[i].exp_writes);
        end

        // Abort at dwell cycle 5 of source 2.
        begin_test();
        push_slots(2);
        exp_q.push_back(128'(0));
        start_scan();
        guard = 0;
        do begin @(negedge clk); guard++; end while (!(sample_win && src_idx == 7'd2) && guard < 2000);
        check("reach_dwell_src2", 128'(guard < 2000), 128'(1));
        repeat (4) @(posedge clk);
        #1 scan_stop = 1'b1;
        @(negedge clk);
        check("stop_drops_window", 128'(sample_win), 128'(0));
        @(posedge clk); #1 scan_stop = 1'b0;
        wait_idle("stop_dwell");
        check("stop_dwell_no_frame_done", 128'(fd_cnt - fd_base), 128'(0));
        check("stop_dwell_windows", 128'(win_q.size()), 128'(3));
        if (win_q.size() == 3) check("stop_dwell_cut_len", 128'(win_q[2].len), 128'(4));
        check("stop_dwell_writes", 128'(n_latch - latch_base), 128'(4));
        check("stop_dwell_outstanding", 128'(exp_q.size()), 128'(0));

        // Abort during the write request of source 1.
        begin_test();
        push_slots(1);
        exp_q.push_back(128'(0));
        start_scan();
        guard = 0;
        do begin @(negedge clk); guard++; end while (!(bus.hc595d_wr_en && src_idx == 7'd1) && guard < 2000);
        check("reach_wr_req_src1", 128'(guard < 2000), 128'(1));
        scan_stop = 1'b1;
        @(posedge clk); #1 scan_stop = 1'b0;
        wait_idle("stop_wr_req");
        check("stop_wr_req_windows", 128'(win_q.size()), 128'(1));
        if (win_q.size() > 0) check("stop_wr_req_win_idx", 128'(win_q[0].idx), 128'(0));
        check("stop_wr_req_no_frame_done", 128'(fd_cnt - fd_base), 128'(0));
        check("stop_wr_req_writes", 128'(n_latch - latch_base), 128'(3));
        check("stop_wr_req_outstanding", 128'(exp_q.size()), 128'(0));

        // Driver busy when scan_en arrives: stay idle.
        drv_hold_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1 scan_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("driver_busy_stays_idle", 128'(busy), 128'(0));
        scan_en       = 1'b0;
        drv_hold_busy = 1'b0;
        repeat (2) @(posedge clk);

        // Driver never responds: timeout after WR_TIMEOUT cycles.
        drv_no_resp = 1'b1;
        start_scan();
        guard = 0;
        do begin @(negedge clk); guard++; end while (!bus.hc595d_wr_en && guard < 50);
        cnt = 0;
        while (bus.hc595d_wr_en && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_cycles", 128'(cnt), 128'(WR_TIMEOUT));
        check("timeout_wr_err", 128'(wr_err), 128'(1));
        check("timeout_idle", 128'(busy), 128'(0));
        repeat (3) @(negedge clk);
        check("wr_err_sticky", 128'(wr_err), 128'(1));
        drv_no_resp = 1'b0;

        // Restart clears wr_err; then reset lands in the middle of source 1's ack.
        exp_q.push_back(128'(1));
        start_scan();
        @(negedge clk);
        check("restart_clears_wr_err", 128'(wr_err), 128'(0));
        guard = 0;
        do begin @(negedge clk); guard++; end
        while (!(src_idx == 7'd1 && busy && !bus.hc595d_wr_en && !bus.hc595d_wr_finish) && guard < 2000);
        check("reach_wr_ack_src1", 128'(guard < 2000), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_data", bus.hc595d_data, 128'(0));
        check("async_reset_len", 128'(bus.hc595d_data_len), 128'(0));
        check("async_reset_misc", 128'({bus.hc595d_wr_en, src_idx, sample_win, frame_done, busy, wr_err}), 128'(0));
        check("reset_outstanding", 128'(exp_q.size()), 128'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_frames(1);
        verify_frames(1, 5, 6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
